// File: rtl/z16_led_uart_tx.sv
// LED-bus change observer: queues {2'b01, led} on every LED change and
// serialises the queued bytes as UART 8N1 frames on o_tx.
module z16_led_uart_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [5:0]                    i_led,
    input  logic                          i_en,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    logic [5:0]       r_prev_led;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_overflow;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_baud;
    logic [DIV_W-1:0] w_baud_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;

    logic             w_change;
    logic             w_req;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_byte;

    assign w_change = (i_led != r_prev_led);
    assign w_req    = w_change && i_en;
    assign w_full   = (r_cnt == CNT_W'(FIFO_DEPTH));
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign w_push   = w_req && (!w_full || w_pop);
    assign w_byte   = {2'b01, i_led};

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_led <= 6'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev_led <= i_led;
            r_cnt      <= w_cnt_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_byte;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tx_nxt = 1'b1;
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = DIV_W'(CLK_DIV - 1);
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (r_baud == '0) begin
                    w_state_nxt   = StData;
                    w_bit_idx_nxt = 3'd0;
                    w_baud_nxt    = DIV_W'(CLK_DIV - 1);
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud - DIV_W'(1);
                end
            end
            StData: begin
                if (r_baud == '0) begin
                    w_baud_nxt = DIV_W'(CLK_DIV - 1);
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = StStop;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - DIV_W'(1);
                end
            end
            StStop: begin
                if (r_baud == '0) begin
                    w_state_nxt   = StIdle;
                    w_bit_idx_nxt = 3'd0;
                end else begin
                    w_baud_nxt = r_baud - DIV_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = (r_state != StIdle) || (r_cnt != '0);
    assign o_overflow = r_overflow;
    assign o_fifo_cnt = r_cnt;

endmodule

// File: tb/tb_z16_led_uart_tx.sv
// Self-checking bench for z16_led_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_z16_led_uart_tx;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [5:0] i_led;
    logic       i_en;
    logic       o_tx;
    logic       o_busy;
    logic       o_overflow;
    logic [2:0] o_fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [5:0] led;
        logic       en;
        logic       exp_frame;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[13];

    z16_led_uart_tx #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_led      (i_led),
        .i_en       (i_en),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_fifo_cnt (o_fifo_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right after the push edge k; checks o_tx for cycles k+1..k+40.
    task automatic frame_exact(input logic [7:0] b);
        logic exp;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (j <= 4)       exp = 1'b0;
            else if (j <= 36) exp = b[(j - 5) / 4];
            else              exp = 1'b1;
            check($sformatf("frame_exact_%0h_cyc%0d", b, j), o_tx, exp);
            if (j == 40) check("busy_last_stop_cycle", o_busy, 1);
        end
    endtask

    // UART receiver: waits for a start bit, then samples mid-bit.
    task automatic rx(output logic [7:0] b, output int t0);
        bit ok = 0;
        int off;
        b  = 8'h00;
        t0 = 0;
        for (int n = 0; n < 120; n++) begin
            step();
            if (o_tx == 1'b0) begin
                ok = 1;
                break;
            end
        end
        check("rx_start_seen", ok, 1);
        if (!ok) return;
        t0  = cyc;
        off = 0;
        while (off < 2) begin step(); off++; end
        check("rx_start_bit", o_tx, 0);
        for (int i = 0; i < 8; i++) begin
            while (off < 5 + 4 * i) begin step(); off++; end
            b[i] = o_tx;
        end
        while (off < 37) begin step(); off++; end
        check("rx_stop_bit", o_tx, 1);
        while (off < 39) begin step(); off++; end
        check("rx_stop_end", o_tx, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (o_busy == 1'b0) break;
            step();
        end
        check("wait_idle", o_busy, 0);
    endtask

    task automatic no_frame(input string name, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_tx == 1'b0 || o_busy == 1'b1) seen = 1;
        end
        check(name, seen, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         t0;
        int         t_prev;

        vecs[0]  = '{6'h01, 1'b1, 1'b1, 8'h41};
        vecs[1]  = '{6'h02, 1'b1, 1'b1, 8'h42};
        vecs[2]  = '{6'h03, 1'b1, 1'b1, 8'h43};
        vecs[3]  = '{6'h04, 1'b1, 1'b1, 8'h44};
        vecs[4]  = '{6'h05, 1'b1, 1'b1, 8'h45};
        vecs[5]  = '{6'h06, 1'b1, 1'b1, 8'h46};
        vecs[6]  = '{6'h07, 1'b1, 1'b1, 8'h47};
        vecs[7]  = '{6'h08, 1'b1, 1'b1, 8'h48};
        vecs[8]  = '{6'h09, 1'b1, 1'b1, 8'h49};
        vecs[9]  = '{6'h0A, 1'b1, 1'b1, 8'h4A};
        vecs[10] = '{6'h20, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{6'h20, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{6'h3F, 1'b1, 1'b1, 8'h7F};

        // Reset state, then first frame after release
        i_rst_n = 1'b0;
        i_led   = 6'h15;
        i_en    = 1'b1;
        repeat (3) step();
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_cnt", o_fifo_cnt, 0);
        i_rst_n = 1'b1;
        step();
        check("rel_push_cnt", o_fifo_cnt, 1);
        check("rel_push_tx", o_tx, 1);
        frame_exact(8'h55);
        step();
        check("rel_done_busy", o_busy, 0);
        check("rel_done_cnt", o_fifo_cnt, 0);

        // Single frame with exact cycle timing
        i_en  = 1'b0;
        i_led = 6'h00;
        step();
        i_en = 1'b1;
        step();
        i_led = 6'h15;
        step();
        check("single_push_cnt", o_fifo_cnt, 1);
        check("single_push_busy", o_busy, 1);
        check("single_push_tx", o_tx, 1);
        frame_exact(8'h55);
        step();
        check("single_busy_fall", o_busy, 0);

        // Burst of six changes into a 4-deep FIFO
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    i_led = 6'(v);
                    step();
                    if (v == 5) begin
                        check("burst_cnt_peak", o_fifo_cnt, 4);
                        check("burst_ovf_before", o_overflow, 0);
                    end
                    if (v == 6) begin
                        check("burst_cnt_full", o_fifo_cnt, 4);
                        check("burst_ovf_set", o_overflow, 1);
                    end
                end
            end
            begin
                t_prev = 0;
                for (int i = 0; i < 5; i++) begin
                    rx(b, t0);
                    check($sformatf("burst_byte%0d", i), b, 8'h41 + 8'(i));
                    if (i > 0) check($sformatf("burst_gap%0d", i), t0 - t_prev, 41);
                    t_prev = t0;
                end
            end
        join
        wait_idle();
        check("burst_ovf_sticky", o_overflow, 1);
        no_frame("burst_dropped_0x46", 30);

        // Enable gating
        i_en  = 1'b0;
        i_led = 6'h3F;
        step();
        i_led = 6'h0A;
        step();
        i_en = 1'b1;
        no_frame("gate_no_stale", 50);
        i_led = 6'h0B;
        step();
        rx(b, t0);
        check("gate_byte", b, 8'h4B);
        wait_idle();
        no_frame("gate_single", 30);

        // Reset mid-frame with two bytes queued
        i_led = 6'h21;
        step();
        i_led = 6'h22;
        step();
        i_led = 6'h23;
        step();
        check("mid_cnt_queued", o_fifo_cnt, 2);
        repeat (16) step();
        check("mid_bit3_low", o_tx, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_tx", o_tx, 1);
        check("mid_rst_cnt", o_fifo_cnt, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ovf", o_overflow, 0);
        repeat (2) step();
        i_rst_n = 1'b1;
        step();
        check("mid_rel_ovf", o_overflow, 0);
        rx(b, t0);
        check("mid_rel_byte", b, 8'h63);
        wait_idle();
        no_frame("mid_no_resume", 30);

        // Reset release with LED at zero emits nothing
        i_en  = 1'b0;
        i_led = 6'h00;
        step();
        i_en    = 1'b1;
        i_rst_n = 1'b0;
        repeat (2) step();
        i_rst_n = 1'b1;
        no_frame("zero_led_after_rst", 50);

        // Table-driven isolated changes; pointers wrap several times
        for (int i = 0; i < 13; i++) begin
            i_en  = vecs[i].en;
            i_led = vecs[i].led;
            step();
            if (vecs[i].exp_frame) begin
                rx(b, t0);
                check($sformatf("vec%0d_byte", i), b, vecs[i].exp_byte);
                wait_idle();
            end else begin
                no_frame($sformatf("vec%0d_no_frame", i), 50);
            end
            check($sformatf("vec%0d_ovf", i), o_overflow, 0);
            check($sformatf("vec%0d_cnt", i), o_fifo_cnt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
